tiny_soc_mmio_responder: RTL and testbench

// - Target end of the tiny-SoC MMIO port. Accepts the core's req/addr/wdata/strb/we requests and returns mmio_rdata.
// - Provides four registers: a stop/exit register, a console TX FIFO that drains over a valid/ready byte stream,
//   a status register and a free-running cycle counter.
// - Sits beside the instruction/data SRAM at SoC top level and is the sole responder on the MMIO bus.

---
 rtl/tiny_soc_mmio_responder.sv | 160 ++++++++++++++++
 tb/tb_tiny_soc_mmio_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_soc_mmio_responder.sv
// MMIO target: sticky stop register, console TX FIFO drained over valid/ready, status word, cycle counter.
// Define TINY_SOC_MMIO_ERR_EN to add sticky err_o/err_addr_o for unmapped accesses and read-only writes.
module tiny_soc_mmio_responder #(
  parameter int unsigned              MMIOAddrWidth = 31,
  parameter int unsigned              DataWidth     = 64,
  parameter logic [MMIOAddrWidth-1:0] BaseAddr      = 'h10000000,
  parameter int unsigned              FifoDepth     = 16,
  localparam int unsigned             StrbWidth     = DataWidth >> 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mmio_req_i,
  input  logic [MMIOAddrWidth-1:0] mmio_addr_i,
  input  logic [DataWidth-1:0]     mmio_wdata_i,
  input  logic [StrbWidth-1:0]     mmio_strb_i,
  input  logic                     mmio_we_i,
  output logic [DataWidth-1:0]     mmio_rdata_o,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_ready_i,
  output logic                     stop_o,
`ifdef TINY_SOC_MMIO_ERR_EN
  output logic [31:0]              stop_code_o,
  output logic                     err_o,
  output logic [MMIOAddrWidth-1:0] err_addr_o
`else
  output logic [31:0]              stop_code_o
`endif
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    REG_STOP   = 2'd0,
    REG_TX     = 2'd1,
    REG_STATUS = 2'd2,
    REG_CYCLE  = 2'd3
  } reg_sel_e;

  logic [MMIOAddrWidth-1:0] offset;
  logic                     mapped;
  reg_sel_e                 sel;

  // Modular subtraction: addresses below BaseAddr wrap to a huge index and fall out as unmapped.
  assign offset = mmio_addr_i - BaseAddr;
  assign mapped = (offset[MMIOAddrWidth-1:5] == '0);
  assign sel    = reg_sel_e'(offset[4:3]);

  logic [7:0]      fifo_mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic [31:0]     ovf_cnt;
  logic [63:0]     cycle_cnt;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push_req;
  logic            push_ok;
  logic            stop_wr;
  logic            err_bit;

  assign empty      = (count == '0);
  assign full       = (count == CntW'(FifoDepth));
  assign tx_valid_o = !empty;
  assign tx_data_o  = fifo_mem[rd_ptr];
  assign pop        = tx_valid_o && tx_ready_i;
  assign push_req   = mmio_req_i && mmio_we_i && mapped && (sel == REG_TX) && mmio_strb_i[0];
  // When full, the slot being popped this edge is the one the push writes into.
  assign push_ok    = push_req && (!full || pop);
  assign stop_wr    = mmio_req_i && mmio_we_i && mapped && (sel == REG_STOP) && (mmio_strb_i[3:0] != '0);

  logic [DataWidth-1:0] status_word;
  logic [DataWidth-1:0] rd_next;

  always_comb begin
    status_word        = '0;
    status_word[63:48] = 16'(count);
    status_word[47:16] = ovf_cnt;
    status_word[2]     = err_bit;
    status_word[1]     = full;
    status_word[0]     = empty;
  end

  always_comb begin
    rd_next = '0;
    if (mapped) begin
      case (sel)
        REG_STOP:   rd_next = {31'b0, stop_o, stop_code_o};
        REG_TX:     rd_next = '0;
        REG_STATUS: rd_next = status_word;
        REG_CYCLE:  rd_next = cycle_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mmio_rdata_o <= '0;
      stop_o       <= 1'b0;
      stop_code_o  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ovf_cnt      <= '0;
      cycle_cnt    <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        fifo_mem[PtrW'(i)] <= '0;
      end
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (mmio_req_i && !mmio_we_i) begin
        mmio_rdata_o <= rd_next;
      end
      if (stop_wr) begin
        stop_o      <= 1'b1;
        stop_code_o <= mmio_wdata_i[31:0];
      end
      if (push_ok) begin
        fifo_mem[wr_ptr] <= mmio_wdata_i[7:0];
        wr_ptr           <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CntW'(1);
      end else if (!push_ok && pop) begin
        count <= count - CntW'(1);
      end
      if (push_req && !push_ok && (ovf_cnt != '1)) begin
        ovf_cnt <= ovf_cnt + 32'd1;
      end
    end
  end

`ifdef TINY_SOC_MMIO_ERR_EN
  logic err_evt;
  assign err_evt = mmio_req_i &&
                   (!mapped || (mmio_we_i && ((sel == REG_STATUS) || (sel == REG_CYCLE))));
  assign err_bit = err_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (err_evt && !err_o) begin
      err_o      <= 1'b1;
      err_addr_o <= mmio_addr_i;
    end
  end
`else
  assign err_bit = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{mmio_wdata_i[DataWidth-1:32], mmio_strb_i[StrbWidth-1:4], offset[2:0]};

endmodule

// File: tb/tb_tiny_soc_mmio_responder.sv
// Self-checking bench for tiny_soc_mmio_responder: vector table for register access plus
// hand-written sequences for cycle counter, FIFO overflow/drain, reset mid-drain and error capture.
module tb_tiny_soc_mmio_responder;

  localparam logic [30:0] BASE = 31'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [30:0] addr;
  logic [63:0] wdata;
  logic [7:0]  strb;
  logic        we;
  logic [63:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        stop;
  logic [31:0] stop_code;
`ifdef TINY_SOC_MMIO_ERR_EN
  logic        err;
  logic [30:0] err_addr;
  localparam logic [63:0] ERR_STAT = 64'h4;
`else
  localparam logic [63:0] ERR_STAT = 64'h0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tiny_soc_mmio_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mmio_req_i   (req),
    .mmio_addr_i  (addr),
    .mmio_wdata_i (wdata),
    .mmio_strb_i  (strb),
    .mmio_we_i    (we),
    .mmio_rdata_o (rdata),
    .tx_valid_o   (tx_valid),
    .tx_data_o    (tx_data),
    .tx_ready_i   (tx_ready),
    .stop_o       (stop),
`ifdef TINY_SOC_MMIO_ERR_EN
    .stop_code_o  (stop_code),
    .err_o        (err),
    .err_addr_o   (err_addr)
`else
    .stop_code_o  (stop_code)
`endif
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [30:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp_rdata;
    logic        exp_stop;
    logic [31:0] exp_code;
    logic        exp_valid;
  } vec_t;

  vec_t        vecs [14];
  logic [7:0]  got [$];
  logic [7:0]  exp_byte;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [30:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    req   = r;
    we    = w;
    addr  = a;
    wdata = d;
    strb  = s;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, BASE + 31'h00, 64'h0000_0000_0000_002A, 8'h0F, 64'd15, 1'b1, 32'h0000_002A, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, BASE + 31'h00, 64'h0, 8'h00, 64'h0000_0001_0000_002A, 1'b1, 32'h0000_002A, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, BASE + 31'h00, 64'hDEAD_BEEF_0000_0077, 8'hF0, 64'h0000_0001_0000_002A, 1'b1, 32'h0000_002A, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, BASE + 31'h03, 64'h0, 8'h00, 64'h0000_0001_0000_002A, 1'b1, 32'h0000_002A, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, BASE + 31'h00, 64'h1234_5678_9ABC_DEF0, 8'h01, 64'h0000_0001_0000_002A, 1'b1, 32'h9ABC_DEF0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, BASE + 31'h00, 64'h0, 8'h00, 64'h0000_0001_9ABC_DEF0, 1'b1, 32'h9ABC_DEF0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, BASE + 31'h08, 64'h0, 8'h00, 64'h0, 1'b1, 32'h9ABC_DEF0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, BASE + 31'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b1, 32'h9ABC_DEF0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, BASE + 31'h10, 64'h0, 8'h00, 64'h1 | ERR_STAT, 1'b1, 32'h9ABC_DEF0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, BASE + 31'h40, 64'h0, 8'h00, 64'h0, 1'b1, 32'h9ABC_DEF0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, BASE - 31'h08, 64'h0, 8'h00, 64'h0, 1'b1, 32'h9ABC_DEF0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, BASE + 31'h08, 64'h55, 8'h02, 64'h0, 1'b1, 32'h9ABC_DEF0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, BASE + 31'h10, 64'h0, 8'h00, 64'h1 | ERR_STAT, 1'b1, 32'h9ABC_DEF0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, BASE + 31'h00, 64'h0, 8'h00, 64'h1 | ERR_STAT, 1'b1, 32'h9ABC_DEF0, 1'b0};

    rst      = 1'b1;
    tx_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_tx_valid", {63'b0, tx_valid}, 64'h0);
    chk("reset_tx_data", {56'b0, tx_data}, 64'h0);
    chk("reset_stop", {63'b0, stop}, 64'h0);
    chk("reset_stop_code", {32'b0, stop_code}, 64'h0);
    rst = 1'b0;

    // Counter is 0 after the last reset edge; a read sampled at edge N returns N-1.
    repeat (10) tick();
    drive(1'b1, 1'b0, BASE + 31'h18, '0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    chk("cycle_read_10", rdata, 64'd10);
    repeat (4) tick();
    drive(1'b1, 1'b0, BASE + 31'h18, '0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    chk("cycle_read_15", rdata, 64'd15);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      tick();
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_stop", i), {63'b0, stop}, {63'b0, vecs[i].exp_stop});
      chk($sformatf("vec%0d_code", i), {32'b0, stop_code}, {32'b0, vecs[i].exp_code});
      chk($sformatf("vec%0d_valid", i), {63'b0, tx_valid}, {63'b0, vecs[i].exp_valid});
    end
    drive(1'b0, 1'b0, '0, '0, '0);

    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, BASE + 31'h08, 64'(i), 8'h01);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    chk("full_tx_valid", {63'b0, tx_valid}, 64'h1);
    chk("full_head_stable", {56'b0, tx_data}, 64'h00);
    drive(1'b1, 1'b0, BASE + 31'h10, '0, '0);
    tick();
    chk("status_full_ovf", rdata, 64'h0010_0000_0001_0002 | ERR_STAT);

    // Pop and push on a full FIFO in the same cycle.
    if (tx_valid) got.push_back(tx_data);
    tx_ready = 1'b1;
    drive(1'b1, 1'b1, BASE + 31'h08, 64'hAB, 8'h01);
    tick();
    tx_ready = 1'b0;
    drive(1'b1, 1'b0, BASE + 31'h10, '0, '0);
    tick();
    chk("status_push_pop_full", rdata, 64'h0010_0000_0001_0002 | ERR_STAT);

    drive(1'b0, 1'b0, '0, '0, '0);
    tx_ready = 1'b1;
    for (int n = 0; n < 40 && got.size() < 17; n++) begin
      if (tx_valid) got.push_back(tx_data);
      tick();
    end
    chk("drain_count", 64'(got.size()), 64'd17);
    for (int k = 0; k < 17; k++) begin
      exp_byte = (k < 16) ? 8'(k) : 8'hAB;
      if (k < got.size()) chk($sformatf("drain_byte%0d", k), {56'b0, got[k]}, {56'b0, exp_byte});
    end
    chk("drain_empty", {63'b0, tx_valid}, 64'h0);
    tx_ready = 1'b0;
    drive(1'b1, 1'b0, BASE + 31'h10, '0, '0);
    tick();
    chk("status_after_drain", rdata, 64'h0000_0000_0001_0001 | ERR_STAT);

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, BASE + 31'h08, 64'h60 + 64'(i), 8'h01);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    tx_ready = 1'b1;
    tick();
    chk("middrain_head", {56'b0, tx_data}, 64'h61);
    rst = 1'b1;
    drive(1'b1, 1'b1, BASE + 31'h08, 64'h77, 8'h01);
    tick();
    rst      = 1'b0;
    tx_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    chk("rst_tx_valid", {63'b0, tx_valid}, 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_stop", {63'b0, stop}, 64'h0);
    chk("rst_stop_code", {32'b0, stop_code}, 64'h0);
    drive(1'b1, 1'b0, BASE + 31'h10, '0, '0);
    tick();
    chk("rst_status", rdata, 64'h1);

`ifdef TINY_SOC_MMIO_ERR_EN
    chk("err_clear_after_rst", {63'b0, err}, 64'h0);
    drive(1'b1, 1'b0, BASE + 31'h40, '0, '0);
    tick();
    drive(1'b1, 1'b1, BASE + 31'h18, 64'hFFFF, 8'hFF);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    chk("err_flag", {63'b0, err}, 64'h1);
    chk("err_addr_first", {33'b0, err_addr}, {33'b0, BASE + 31'h40});
    chk("err_unmapped_rdata", rdata, 64'h0);
    drive(1'b1, 1'b0, BASE + 31'h10, '0, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    chk("err_status_bit", rdata, 64'h5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
